// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: datapath widths and architectural register IDs.
package y86_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 15;

  typedef logic [ADDR_W-1:0] reg_id_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t RR8   = 4'h8;
  localparam reg_id_t RR9   = 4'h9;
  localparam reg_id_t RR10  = 4'hA;
  localparam reg_id_t RR11  = 4'hB;
  localparam reg_id_t RR12  = 4'hC;
  localparam reg_id_t RR13  = 4'hD;
  localparam reg_id_t RR14  = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

endpackage

// File: rtl/register_file_if.sv
// Decode read / write-back write bundle between the SEQ datapath and the register file.
interface register_file_if;
  import y86_pkg::*;

  reg_id_t srcA;
  reg_id_t srcB;
  reg_id_t dstE;
  reg_id_t dstM;
  word_t   valE;
  word_t   valM;
  word_t   valA;
  word_t   valB;

  modport master (
    output srcA, srcB, dstE, dstM, valE, valM,
    input  valA, valB
  );

  modport slave (
    input  srcA, srcB, dstE, dstM, valE, valM,
    output valA, valB
  );

endinterface

// File: rtl/register_file.sv
// Y86-64 register file: 15 x 64-bit, two combinational reads, two write ports (M wins on conflict).
module register_file
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  register_file_if.slave   rf
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  // Write decode; port M is applied last so it overrides port E on the same ID, RNONE never matches.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rf.dstE == ADDR_W'(i)) begin
        regs_d[i] = rf.valE;
      end
      if (rf.dstM == ADDR_W'(i)) begin
        regs_d[i] = rf.valM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read muxes without bypass; RNONE falls through to zero.
  always_comb begin
    rf.valA = '0;
    rf.valB = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rf.srcA == ADDR_W'(i)) begin
        rf.valA = regs_q[i];
      end
      if (rf.srcB == ADDR_W'(i)) begin
        rf.valB = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
module tb_register_file;
  import y86_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] exp_regs [15];

  register_file_if rf_if ();

  register_file u_dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    rf_if.dstE = RNONE;
    rf_if.dstM = RNONE;
    rf_if.valE = 64'h0;
    rf_if.valM = 64'h0;
  endtask

  // Reads every register on port A and port B (reversed order) against the model.
  task automatic sweep(input string tag);
    for (int i = 0; i < 15; i++) begin
      rf_if.srcA = 4'(i);
      rf_if.srcB = 4'(14 - i);
      #1;
      check_eq($sformatf("%s_a%0d", tag, i), rf_if.valA, exp_regs[i]);
      check_eq($sformatf("%s_b%0d", tag, 14 - i), rf_if.valB, exp_regs[14 - i]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 15; i++) exp_regs[i] = 64'h0;

    rst = 1'b1;
    rf_if.srcA = RRAX;
    rf_if.srcB = RRAX;
    idle_writes();
    tick();
    rst = 1'b0;

    // Reset then read.
    rf_if.srcA = RRBP;
    rf_if.srcB = RRDI;
    #1;
    check_eq("rst_rbp", rf_if.valA, 64'h0);
    check_eq("rst_rdi", rf_if.valB, 64'h0);
    sweep("rst_sweep");

    // Dual write in one edge.
    rf_if.dstE = RR8;  rf_if.valE = 64'h012a;
    rf_if.dstM = RR10; rf_if.valM = 64'h0546b;
    tick();
    idle_writes();
    exp_regs[8]  = 64'h012a;
    exp_regs[10] = 64'h0546b;
    rf_if.srcA = RR8;
    rf_if.srcB = RR10;
    #1;
    check_eq("dual_r8", rf_if.valA, 64'h012a);
    check_eq("dual_r10", rf_if.valB, 64'h0546b);
    rf_if.srcA = RRBP;
    rf_if.srcB = RRDI;
    #1;
    check_eq("dual_rbp", rf_if.valA, 64'h0);
    check_eq("dual_rdi", rf_if.valB, 64'h0);

    // Same-ID conflict: M wins.
    rf_if.dstE = RRBX; rf_if.valE = 64'h1111;
    rf_if.dstM = RRBX; rf_if.valM = 64'h2222;
    tick();
    idle_writes();
    exp_regs[3] = 64'h2222;
    rf_if.srcA = RRBX;
    rf_if.srcB = RRBX;
    #1;
    check_eq("conflict_a", rf_if.valA, 64'h2222);
    check_eq("conflict_b", rf_if.valB, 64'h2222);

    // Port M alone to the top register, full-width data.
    rf_if.dstM = RR14; rf_if.valM = 64'hF0E1_D2C3_B4A5_9687;
    tick();
    idle_writes();
    exp_regs[14] = 64'hF0E1_D2C3_B4A5_9687;
    rf_if.srcA = RR14;
    #1;
    check_eq("m_only_r14", rf_if.valA, 64'hF0E1_D2C3_B4A5_9687);

    // RNONE writes have no side effects.
    rf_if.dstE = RNONE; rf_if.valE = 64'hDEAD;
    rf_if.dstM = RNONE; rf_if.valM = 64'hDEAD;
    tick();
    idle_writes();
    sweep("rnone_sweep");
    rf_if.srcA = RNONE;
    rf_if.srcB = RNONE;
    #1;
    check_eq("rnone_rd_a", rf_if.valA, 64'h0);
    check_eq("rnone_rd_b", rf_if.valB, 64'h0);

    // Read-during-write: old value before the edge, new value after.
    rf_if.dstE = RRSP; rf_if.valE = 64'h10;
    tick();
    rf_if.dstE = RRSP; rf_if.valE = 64'h20;
    rf_if.srcA = RRSP;
    #1;
    check_eq("rdw_before", rf_if.valA, 64'h10);
    tick();
    idle_writes();
    exp_regs[4] = 64'h20;
    check_eq("rdw_after", rf_if.valA, 64'h20);

    // Reset has priority over a concurrent write.
    rst = 1'b1;
    rf_if.dstE = RRDX; rf_if.valE = 64'hFF;
    rf_if.dstM = RR9;  rf_if.valM = 64'h77;
    tick();
    rst = 1'b0;
    idle_writes();
    for (int i = 0; i < 15; i++) exp_regs[i] = 64'h0;
    rf_if.srcA = RRDX;
    #1;
    check_eq("rstprio_rdx", rf_if.valA, 64'h0);
    sweep("rstprio_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
